// File: rtl/config_pkg.sv
// Shared types and sizing helpers for the configuration chain loader.
package config_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_VERIFY,
        ST_DONE
    } state_t;

    // Counter width able to hold the value chain_len itself.
    function automatic int cnt_width(input int chain_len);
        return $clog2(chain_len + 1);
    endfunction

    function automatic int words_per_chain(input int chain_len, input int word_w);
        return (chain_len + word_w - 1) / word_w;
    endfunction

    localparam int CHAIN_LEN_DEFAULT = 64;
    localparam int WORD_W_DEFAULT    = 8;
    localparam int WORDS_PER_CHAIN   = words_per_chain(CHAIN_LEN_DEFAULT, WORD_W_DEFAULT);

endpackage

// File: rtl/word_serializer.sv
// Holding shift register that turns accepted host words into an LSB-first bit
// stream, trimming the last word so exactly CHAIN_LEN bits are ever produced.
module word_serializer
    import config_pkg::*;
#(
    parameter int CHAIN_LEN = 64,
    parameter int WORD_W    = 8,
    parameter int CNT_W     = cnt_width(CHAIN_LEN)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_active,
    input  logic [CNT_W-1:0]  bit_cnt,
    input  logic [WORD_W-1:0] word_in,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              ser_bit,
    output logic              ser_valid
);

    localparam int LEFT_W = $clog2(WORD_W + 1);
    localparam int SUM_W  = CNT_W + 1;

    logic [WORD_W-1:0] hold_reg;
    logic [LEFT_W-1:0] left_reg;
    logic [SUM_W-1:0]  committed;
    logic [SUM_W-1:0]  room;
    logic [LEFT_W-1:0] load_len;
    logic              take;

    // Bits already presented plus bits still waiting in the holding register.
    assign committed  = SUM_W'(bit_cnt) + SUM_W'(left_reg);
    assign room       = SUM_W'(CHAIN_LEN) - committed;
    assign load_len   = (room < SUM_W'(WORD_W)) ? LEFT_W'(room) : LEFT_W'(WORD_W);

    assign word_ready = load_active && (left_reg <= LEFT_W'(1)) &&
                        (committed < SUM_W'(CHAIN_LEN));
    assign take       = word_ready && word_valid;
    assign ser_bit    = hold_reg[0];
    assign ser_valid  = (left_reg != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_reg <= '0;
            left_reg <= '0;
        end else if (take) begin
            hold_reg <= word_in;
            left_reg <= load_len;
        end else if (left_reg != '0) begin
            hold_reg <= hold_reg >> 1;
            left_reg <= left_reg - LEFT_W'(1);
        end
    end

endmodule

// File: rtl/config_loader.sv
// Chain head sequencer: serialises host words into the configuration chain and
// optionally rotates the chain once through itself to check the ones count.
module config_loader
    import config_pkg::*;
#(
    parameter int CHAIN_LEN = 64,
    parameter int WORD_W    = 8,
    parameter int CNT_W     = cnt_width(CHAIN_LEN)
) (
    input  logic              config_clk,
    input  logic              sys_reset,
    input  logic              start,
    input  logic              verify,
    input  logic [WORD_W-1:0] word_in,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              chain_data,
    output logic              chain_en,
    input  logic              chain_return,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);

    state_t           state_reg;
    logic             verify_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             error_reg;
    logic [CNT_W-1:0] bit_cnt_reg;
    logic [CNT_W-1:0] ones_cnt_reg;
    logic [CNT_W-1:0] ones_after;
    logic             load_active;
    logic             ser_bit;
    logic             ser_valid;

    assign load_active = (state_reg == ST_LOAD);

    word_serializer #(
        .CHAIN_LEN (CHAIN_LEN),
        .WORD_W    (WORD_W),
        .CNT_W     (CNT_W)
    ) u_serializer (
        .clk         (config_clk),
        .rst_n       (sys_reset),
        .load_active (load_active),
        .bit_cnt     (bit_cnt_reg),
        .word_in     (word_in),
        .word_valid  (word_valid),
        .word_ready  (word_ready),
        .ser_bit     (ser_bit),
        .ser_valid   (ser_valid)
    );

    assign chain_en   = (load_active && ser_valid) || (state_reg == ST_VERIFY);
    assign ones_after = ones_cnt_reg - CNT_W'(chain_return);
    assign busy       = busy_reg;
    assign done       = done_reg;
    assign error      = error_reg;

    // During the check lap the chain feeds itself, so its contents survive.
    always_comb begin
        chain_data = 1'b0;
        case (state_reg)
            ST_LOAD:   chain_data = ser_valid & ser_bit;
            ST_VERIFY: chain_data = chain_return;
            default:   chain_data = 1'b0;
        endcase
    end

    always_ff @(posedge config_clk or negedge sys_reset) begin
        if (!sys_reset) begin
            state_reg    <= ST_IDLE;
            verify_reg   <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            error_reg    <= 1'b0;
            bit_cnt_reg  <= '0;
            ones_cnt_reg <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        state_reg    <= ST_LOAD;
                        verify_reg   <= verify;
                        busy_reg     <= 1'b1;
                        error_reg    <= 1'b0;
                        bit_cnt_reg  <= '0;
                        ones_cnt_reg <= '0;
                    end
                end
                ST_LOAD: begin
                    if (ser_valid) begin
                        bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
                        if (ser_bit) begin
                            ones_cnt_reg <= ones_cnt_reg + CNT_W'(1);
                        end
                        if (bit_cnt_reg == LAST_BIT) begin
                            if (verify_reg) begin
                                state_reg   <= ST_VERIFY;
                                bit_cnt_reg <= '0;
                            end else begin
                                state_reg <= ST_DONE;
                                busy_reg  <= 1'b0;
                                done_reg  <= 1'b1;
                            end
                        end
                    end
                end
                ST_VERIFY: begin
                    // bit_cnt_reg doubles as the lap counter here.
                    bit_cnt_reg  <= bit_cnt_reg + CNT_W'(1);
                    ones_cnt_reg <= ones_after;
                    if (bit_cnt_reg == LAST_BIT) begin
                        error_reg <= (ones_after != '0);
                        state_reg <= ST_DONE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
